// File: rtl/qpsk_symbol_mapper_if.sv
// ============================================================================
// qpsk_symbol_mapper_if : bit-input handshake, symbol sample inputs, output stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface qpsk_symbol_mapper_if;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [8:0] sym00_in;
  logic [8:0] sym01_in;
  logic [8:0] sym10_in;
  logic [8:0] sym11_in;
  logic [8:0] mod_out;
  logic       mod_valid;
  logic       sym_start;
  logic       underrun;

  modport slave (
    input  bit_in, bit_valid, sym00_in, sym01_in, sym10_in, sym11_in,
    output bit_ready, mod_out, mod_valid, sym_start, underrun
  );

  modport master (
    output bit_in, bit_valid, sym00_in, sym01_in, sym10_in, sym11_in,
    input  bit_ready, mod_out, mod_valid, sym_start, underrun
  );
endinterface

`default_nettype wire

// File: rtl/qpsk_symbol_mapper.sv
// ============================================================================
// qpsk_symbol_mapper : packs serial bits into dibits, buffers them and selects
// one of four symbol waveforms per 16-sample slot. Macro GRAY_MAP_EN selects
// Gray dibit mapping (natural binary when undefined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module qpsk_symbol_mapper #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  qpsk_symbol_mapper_if.slave  bus
);

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;

  logic [1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          half_vld_q, half_bit_q;
  logic [3:0]    phase_q;
  state_t        state_q, prev_state_q;
  logic [1:0]    cur_sym_q;
  logic [8:0]    mod_out_q;
  logic          mod_valid_q, sym_start_q, underrun_q;

  logic          w_full, w_empty, w_ready, w_xfer, w_wr, w_pop, w_last;
  logic [8:0]    w_sample;

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);
  assign w_ready = ~rst & ~(w_full & half_vld_q);
  assign w_xfer  = bus.bit_valid & w_ready;
  assign w_wr    = w_xfer & half_vld_q;
  assign w_last  = (phase_q == 4'd15);
  assign w_pop   = w_last & ~w_empty;

  always_comb begin
    count_d = count_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      fifo_mem_q[wr_ptr_q] <= {half_bit_q, bus.bit_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      half_vld_q <= 1'b0;
      half_bit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (w_xfer) begin
        half_vld_q <= ~half_vld_q;
        if (!half_vld_q) begin
          half_bit_q <= bus.bit_in;
        end
      end
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    w_sample = bus.sym00_in;
    case (cur_sym_q)
`ifdef GRAY_MAP_EN
      2'b00: w_sample = bus.sym00_in;
      2'b01: w_sample = bus.sym01_in;
      2'b11: w_sample = bus.sym10_in;
      2'b10: w_sample = bus.sym11_in;
`else
      2'b00: w_sample = bus.sym00_in;
      2'b01: w_sample = bus.sym01_in;
      2'b10: w_sample = bus.sym10_in;
      2'b11: w_sample = bus.sym11_in;
`endif
      default: w_sample = bus.sym00_in;
    endcase
  end

  // Slot FSM: the symbol and state only move at the phase-15 boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= 4'd0;
      state_q      <= S_IDLE;
      prev_state_q <= S_IDLE;
      cur_sym_q    <= 2'b00;
      mod_out_q    <= 9'd0;
      mod_valid_q  <= 1'b0;
      sym_start_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      phase_q <= phase_q + 4'd1;
      if (w_last) begin
        prev_state_q <= state_q;
        if (w_pop) begin
          cur_sym_q <= fifo_mem_q[rd_ptr_q];
          state_q   <= S_DATA;
        end else begin
          state_q   <= S_IDLE;
        end
      end
      mod_valid_q <= (state_q == S_DATA);
      mod_out_q   <= (state_q == S_DATA) ? w_sample : 9'd0;
      sym_start_q <= (phase_q == 4'd0);
      underrun_q  <= (phase_q == 4'd0) && (state_q == S_IDLE) && (prev_state_q == S_DATA);
    end
  end

  assign bus.bit_ready = w_ready;
  assign bus.mod_out   = mod_out_q;
  assign bus.mod_valid = mod_valid_q;
  assign bus.sym_start = sym_start_q;
  assign bus.underrun  = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_qpsk_symbol_mapper.sv
// Scoreboard bench for qpsk_symbol_mapper: stimulus pushes expected samples,
// a negedge monitor pops and compares them against the output stream.
`default_nettype none

module tb_qpsk_symbol_mapper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpsk_symbol_mapper_if bus ();

  qpsk_symbol_mapper #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [8:0] T01 [16] = '{9'd41, 9'd87, 9'd130, 9'd170, 9'd200, 9'd220, 9'd230, 9'd235,
                                       9'd230, 9'd220, 9'd200, 9'd170, 9'd130, 9'd87, 9'd50, 9'd10};

  logic [3:0] tb_phase = 4'd0;
  always @(posedge clk) tb_phase <= rst ? 4'd0 : tb_phase + 4'd1;

  assign bus.sym00_in = 9'd100 + 9'(tb_phase);
  assign bus.sym01_in = T01[tb_phase];
  assign bus.sym10_in = 9'd200 + 9'(tb_phase);
  assign bus.sym11_in = 9'd300 + 9'(tb_phase);

  function automatic logic [8:0] exp_sample(input logic [1:0] d, input int p);
    logic [1:0] src;
`ifdef GRAY_MAP_EN
    case (d)
      2'b00:   src = 2'd0;
      2'b01:   src = 2'd1;
      2'b11:   src = 2'd2;
      default: src = 2'd3;
    endcase
`else
    src = d;
`endif
    case (src)
      2'd0:    return 9'(100 + p);
      2'd1:    return T01[p];
      2'd2:    return 9'(200 + p);
      default: return 9'(300 + p);
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [8:0] exp_q[$];
  logic rst_p = 1'b1, rst_pp = 1'b1;
  always @(posedge clk) begin
    rst_p  <= rst;
    rst_pp <= rst_p;
  end

  int  idx = 0, gap = 0, n_starts = 0, under_cnt = 0, run = 0, last_run = 0, valid_since_rst = 0;
  bit  seen_start = 0, ready_low_seen = 0;

  always @(negedge clk) begin
    if (rst) check(bus.bit_ready == 1'b0, "ready_in_rst", int'(bus.bit_ready), 0);
    if (rst_p) begin
      check({bus.mod_out, bus.mod_valid, bus.sym_start, bus.underrun} == 12'd0, "rst_outputs",
            int'({bus.mod_out, bus.mod_valid, bus.sym_start, bus.underrun}), 0);
      exp_q.delete();
      idx = 0; gap = 0; seen_start = 0; n_starts = 0; run = 0; valid_since_rst = 0;
    end else begin
      if (rst_pp) check(bus.bit_ready == 1'b1, "ready_after_rst", int'(bus.bit_ready), 1);
      if (!rst && !bus.bit_ready) ready_low_seen = 1;
      gap++;
      if (bus.sym_start) begin
        if (seen_start) check(gap == 16, "sym_start_period", gap, 16);
        gap = 0; seen_start = 1; n_starts++;
      end
      if (bus.underrun) begin
        under_cnt++;
        check(bus.sym_start && !bus.mod_valid, "underrun_align",
              int'({bus.sym_start, bus.mod_valid}), 2);
      end
      if (bus.mod_valid) begin
        valid_since_rst++;
        run++;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_sample", int'(bus.mod_out), -1);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check(bus.mod_out == e, "sample", int'(bus.mod_out), int'(e));
          if (idx == 0) check(bus.sym_start == 1'b1, "sym_start_align", int'(bus.sym_start), 1);
          idx = (idx + 1) % 16;
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        check(bus.mod_out == 9'd0, "idle_out", int'(bus.mod_out), 0);
      end
    end
  end

  logic tb_half = 1'b0;
  logic tb_first = 1'b0;

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    while (!bus.bit_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check(1'b0, "ready_timeout", n, 500);
    end else begin
      @(posedge clk);
      if (!tb_half) begin
        tb_half  = 1'b1;
        tb_first = b;
      end else begin
        for (int p = 0; p < 16; p++) exp_q.push_back(exp_sample({tb_first, b}, p));
        tb_half = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_dibit(input logic [1:0] d);
    send_bit(d[1]);
    send_bit(d[0]);
  endtask

  task automatic go_idle();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(n < 3000, "drain_timeout", n, 3000);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_phase(input logic [3:0] ph, input bit need_valid);
    int n;
    n = 0;
    while (!(tb_phase == ph && (!need_valid || bus.mod_valid)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(n < 400, "phase_wait_timeout", n, 400);
  endtask

  localparam logic [1:0] STREAM [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};

  initial begin
    int u0;
    go_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: no data, regular sym_start, no underrun.
    repeat (64) @(negedge clk);
    check(under_cnt == 0, "idle_no_underrun", under_cnt, 0);
    check(n_starts == 4, "idle_start_count", n_starts, 4);
    check(valid_since_rst == 0, "idle_no_valid", valid_since_rst, 0);

    // Single dibit 01 then underrun.
    u0 = under_cnt;
    send_dibit(2'b01);
    go_idle();
    wait_drain();
    check(under_cnt == u0 + 1, "single_underrun", under_cnt, u0 + 1);
    check(last_run == 16, "single_run", last_run, 16);

    // Continuous stream of 10 dibits.
    u0 = under_cnt;
    ready_low_seen = 0;
    for (int i = 0; i < 10; i++) send_dibit(STREAM[i]);
    go_idle();
    wait_drain();
    check(last_run == 160, "stream_run", last_run, 160);
    check(ready_low_seen == 1'b1, "stream_backpressure", int'(ready_low_seen), 1);
    check(under_cnt == u0 + 1, "stream_underrun", under_cnt, u0 + 1);

    // Fill FIFO early in a slot, then transfer a bit on the phase-15 pop edge.
    wait_phase(4'd0, 1'b0);
    send_dibit(2'b10);
    send_dibit(2'b01);
    send_dibit(2'b11);
    send_dibit(2'b00);
    go_idle();
    wait_phase(4'd15, 1'b0);
    send_dibit(2'b10);
    go_idle();
    wait_drain();
    check(last_run == 80, "full_pop_run", last_run, 80);

    // Dibit 11 exercises the mapping choice.
    send_dibit(2'b11);
    go_idle();
    wait_drain();
    check(last_run == 16, "map11_run", last_run, 16);

    // Reset in the middle of a data symbol discards everything queued.
    u0 = under_cnt;
    send_dibit(2'b00);
    send_dibit(2'b11);
    send_dibit(2'b01);
    go_idle();
    wait_phase(4'd7, 1'b1);
    rst = 1'b1;
    tb_half = 1'b0;
    @(negedge clk);
    check(bus.mod_valid == 1'b0 && bus.mod_out == 9'd0, "rst_mid_symbol",
          int'({bus.mod_valid, bus.mod_out}), 0);
    rst = 1'b0;
    repeat (48) @(negedge clk);
    check(valid_since_rst == 0, "rst_flushed", valid_since_rst, 0);
    check(under_cnt == u0, "rst_no_underrun", under_cnt, u0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qpsk_symbol_mapper.md
QPSK_SYMBOL_MAPPER -- requirements
Module: qpsk_symbol_mapper

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, dibit buffer depth (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bit_in  input  1  serial data bit.
REQ-005 bit_valid  input  1  bit_in SHALL be valid while this is high.
REQ-006 bit_ready  output  1  high when the block can accept bit_in.
REQ-007 sym00_in, sym01_in, sym10_in, sym11_in  input  9 each  unsigned samples from the four symbol waveform generators, phase-aligned to the block's sample phase.
REQ-008 mod_out  output  9  modulated sample stream.
REQ-009 mod_valid  output  1  high when mod_out carries a data symbol sample.
REQ-010 sym_start  output  1  one-cycle pulse aligned with sample 0 of each output symbol.
REQ-011 underrun  output  1  one-cycle pulse when a symbol slot starts with an empty buffer.

Function
REQ-012 A bit transfer SHALL occur on a cycle where bit_valid and bit_ready are both high.
REQ-013 Transferred bits SHALL be paired into dibits; the first bit is the MSB and the second bit the LSB.
REQ-014 A one-bit half register SHALL hold the first bit until the second bit arrives.
REQ-015 A completed dibit SHALL be written to a FIFO_DEPTH-entry FIFO in the same cycle the second bit transfers.
REQ-016 bit_ready SHALL be low when the FIFO is full and the half register is occupied; otherwise it SHALL be high.
REQ-017 A FIFO write and a FIFO pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-018 A 4-bit phase counter SHALL count 0..15 and wrap to 0 continuously from reset.
REQ-019 On each cycle where phase==15, the block SHALL pop the FIFO head into cur_sym if the FIFO is non-empty; otherwise cur_sym SHALL become IDLE.
REQ-020 The block SHALL run a two-state FSM with states IDLE and DATA. The FSM SHALL enter DATA on a successful pop and enter IDLE on an empty-buffer slot. The state SHALL change only at phase 15.
REQ-021 When the FSM is in DATA, mod_out SHALL be the sample from the sym input selected by cur_sym, registered with 1-cycle latency.
REQ-022 When the FSM is in IDLE, mod_out SHALL be 0.
REQ-023 mod_valid SHALL be high for all 16 samples of a DATA symbol and low for IDLE, with the same 1-cycle latency as mod_out.
REQ-024 sym_start SHALL pulse on the mod_out sample corresponding to phase 0, in both DATA and IDLE states.
REQ-025 underrun SHALL pulse, aligned with sym_start, only for an IDLE slot that directly follows a DATA symbol.
REQ-026 Symbol selection SHALL never change mid-symbol; a dibit arriving mid-slot SHALL wait for the next boundary.

Reset
REQ-027 On rst, the block SHALL reset phase to 0, FSM to IDLE, the FIFO to empty, and the half register to empty.
REQ-028 On rst, mod_out SHALL be 0, and mod_valid, sym_start and underrun SHALL be 0.
REQ-029 On rst, bit_ready SHALL be 0 while rst is high and 1 in the first cycle after rst is released.
REQ-030 rst asserted mid-symbol SHALL discard the current symbol, the buffered dibits and any half bit.

Configuration
REQ-031 With GRAY_MAP_EN defined, the dibit-to-input selection SHALL be Gray mapping: 00->sym00_in, 01->sym01_in, 11->sym10_in, 10->sym11_in.
REQ-032 With GRAY_MAP_EN undefined, the dibit-to-input selection SHALL be natural binary: dibit dd SHALL select symdd_in.

Verification
REQ-033 Reset release with no input -> mod_out=0 and mod_valid=0 throughout; sym_start every 16 cycles; underrun never pulses.
REQ-034 Send bits 0,1 with sym01_in driven to the sample table 41,87,...,10 -> at the next boundary, 16 samples equal that table with mod_valid=1, then 0 with one underrun pulse.
REQ-035 Stream 10 dibits continuously -> mod_valid stays high for 160 cycles with no gaps; bit_ready deasserts once the FIFO and half register are full.
REQ-036 Apply rst at phase 7 of a DATA symbol -> the next cycle shows mod_out=0, mod_valid=0 and an empty FIFO; the previously queued dibits never appear.
REQ-037 Send dibit 11 with and without GRAY_MAP_EN -> output follows sym10_in and sym11_in respectively.
REQ-038 Perform a bit transfer on the same cycle as a pop at phase 15 with a full FIFO -> no dibit is lost and FIFO order is preserved.
